display_scan_scheduler: RTL and testbench
=========================================

# display_scan_scheduler

Shares the four-digit seven-segment display between two requesters and sequences the digit scan. Each requester asks for the display with a request/grant handshake. Ownership changes only at frame boundaries and respects a minimum dwell, so a shown value is never torn mid-frame. The block sits between the value sources (switch bank, status producers) and the hex-to-cathode decoder, and replaces the free-running refresh counter and anode decode.

## Interface
Parameters:
- REFRESH_DIVIDE, 100000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off (anti-ghosting); 0 ≤ BLANK_CYCLES < REFRESH_DIVIDE.
- DWELL_FRAMES, 2: minimum frames an owner keeps the display once granted; ≥ 1.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_a  in  1  requester A wants the display (low priority).
- data_a  in  16  requester A value, 4 hex nibbles, nibble 0 = rightmost digit.
- req_b  in  1  requester B wants the display (high priority).
- data_b  in  16  requester B value.
- grant_a  out  1  A owns the display for the current frame.
- grant_b  out  1  B owns the display for the current frame.
- anode  out  4  active-low digit enables; 4'b1111 = all off.
- digit  out  4  hex nibble for the active slot, to the cathode decoder.
- frame_done  out  1  one-cycle pulse in the first cycle of each frame.

## Operation
- Slot counter runs 0..REFRESH_DIVIDE-1. Slot index runs 0..3 and advances when the counter wraps. A frame is 4 slots (4*REFRESH_DIVIDE cycles). Counters free-run whenever reset_n is high, owner or not.
- Per-slot phases:
  - BLANK: counter < BLANK_CYCLES; anode = 4'b1111.
  - ON: the remaining cycles; anode has a single 0 at bit = slot index (slot0 → 1110, slot1 → 1101, slot2 → 1011, slot3 → 0111).
- digit = frame_value[4*slot+3 : 4*slot] in both phases.
- With no owner, anode stays 4'b1111 in both phases.
- Boundary = last cycle of slot 3. On the boundary edge, the arbiter updates grant_a/grant_b and captures frame_value from the newly granted source's data. frame_value holds for the whole frame, so data changes mid-frame are invisible until the next frame.
- Arbitration at each boundary. Owner X has dwell count d; "other" is the other requester.
  - No owner: req_b → grant B; else req_a → grant A; else none.
  - Owner X with req_X low: release; grant the other if it requests, else none.
  - Owner X with req_X high and d+1 < DWELL_FRAMES: keep X.
  - Owner X with req_X high and d+1 ≥ DWELL_FRAMES: switch to the other if it requests, else keep X.
  - New grant sets d to 0. Keeping the owner increments d, saturating at DWELL_FRAMES.
- grant_a and grant_b are never both 1.
- Requests are level-sensitive. Requests dropped and reasserted between boundaries are not seen.

## Timing
- Reset values (asynchronous, immediate, also mid-frame): anode 4'b1111, digit 0, grant_a 0, grant_b 0, frame_done 0, frame_value 0, slot 0, counter 0, d 0.
- First cycle after reset release is frame cycle 0, slot 0, BLANK phase. No frame_done pulse for this first frame.
- Grant latency: a request seen at a boundary takes effect in the next cycle. Worst case from request assertion is one full frame plus 1 cycle.
- frame_done is 1 exactly in frame cycle 0 of every frame after the first, including idle frames.
- All outputs are registered. No combinational path from inputs to outputs.
- BLANK_CYCLES = 0: no blank phase; an anode is active every cycle while an owner exists.

## Test plan
Use REFRESH_DIVIDE=8, BLANK_CYCLES=2, DWELL_FRAMES=2 (frame = 32 cycles).
- Idle: reset, no requests → anode stays 4'b1111, grants 0, frame_done pulses every 32 cycles starting at cycle 32.
- Single requester: req_a=1, data_a=16'h1234 from reset → grant_a=1 at cycle 32. Frame 2 shows:
  - slot0: cycles 0–1 anode 1111, cycles 2–7 anode 1110 with digit 4.
  - then 1101/3, 1011/2, 0111/1.
- Dwell and switch: A granted at frame 2; req_b=1, data_b=16'hABCD asserted mid-frame 2 → A keeps frames 2 and 3. grant_b=1 and grant_a=0 from frame 4, whose digits show D, C, B, A.
- Priority: req_a and req_b both rise on the same cycle while idle → grant_b at the next boundary; grant_a stays 0.
- Coherence and release: change data_a to 16'hFFFF mid-frame → current frame keeps showing 1234, the next frame shows FFFF. Drop req_a → grant_a stays 1 through the frame end, then 0 and anode 1111.
- Async reset: pull reset_n low mid-ON-phase between clock edges → anode 4'b1111 and grants 0 immediately. After release, the counters restart from slot 0, counter 0.

Source files
------------

// File: rtl/display_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_scheduler
// Purpose  : Frame-coherent two-requester arbiter and four-digit scan
//            sequencer for a multiplexed seven-segment display. Ownership
//            and the displayed value only change on frame boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_scheduler #(
  parameter int REFRESH_DIVIDE = 100000,
  parameter int BLANK_CYCLES   = 1000,
  parameter int DWELL_FRAMES   = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_a,
  input  logic [15:0] data_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  output logic        grant_a,
  output logic        grant_b,
  output logic [3:0]  anode,
  output logic [3:0]  digit,
  output logic        frame_done
);

  localparam int CW = (REFRESH_DIVIDE > 2) ? $clog2(REFRESH_DIVIDE) : 1;
  localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES + 1) : 1;

  localparam logic [CW-1:0] c_CNT_MAX  = CW'(REFRESH_DIVIDE - 1);
  localparam logic [CW-1:0] c_BLANK    = CW'(BLANK_CYCLES);
  localparam logic [DW-1:0] c_DWELL_MX = DW'(DWELL_FRAMES);
  localparam logic [DW-1:0] c_DWELL_M1 = DW'(DWELL_FRAMES - 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  owner_t        r_owner, w_owner_nxt;
  logic [DW-1:0] r_dwell, w_dwell_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    r_slot, w_slot_nxt;
  logic [15:0]   r_frame_value, w_fv_nxt;
  logic          r_grant_a, r_grant_b, r_frame_done;
  logic [3:0]    r_anode, r_digit, w_anode_nxt, w_digit_nxt;
  logic          w_wrap, w_boundary, w_own_req, w_other_req;

  // Free-running slot counter and slot index; boundary is the last cycle of slot 3
  always_comb begin
    w_wrap     = (r_cnt == c_CNT_MAX);
    w_boundary = w_wrap && (r_slot == 2'd3);
    w_cnt_nxt  = w_wrap ? '0 : r_cnt + 1'b1;
    w_slot_nxt = w_wrap ? r_slot + 2'd1 : r_slot;
  end

  // Owner arbitration: B wins ties, dwell guards against early hand-over
  always_comb begin
    w_owner_nxt = r_owner;
    w_dwell_nxt = r_dwell;
    w_own_req   = (r_owner == OWN_A) ? req_a : req_b;
    w_other_req = (r_owner == OWN_A) ? req_b : req_a;
    if (w_boundary) begin
      case (r_owner)
        OWN_NONE: begin
          w_dwell_nxt = '0;
          if (req_b)      w_owner_nxt = OWN_B;
          else if (req_a) w_owner_nxt = OWN_A;
          else            w_owner_nxt = OWN_NONE;
        end
        default: begin
          if (!w_own_req) begin
            w_dwell_nxt = '0;
            if (w_other_req) w_owner_nxt = (r_owner == OWN_A) ? OWN_B : OWN_A;
            else             w_owner_nxt = OWN_NONE;
          end else if ((r_dwell < c_DWELL_M1) || !w_other_req) begin
            if (r_dwell != c_DWELL_MX) w_dwell_nxt = r_dwell + 1'b1;
          end else begin
            w_dwell_nxt = '0;
            w_owner_nxt = (r_owner == OWN_A) ? OWN_B : OWN_A;
          end
        end
      endcase
    end
  end

  // Next frame value and the anode/digit pattern for the upcoming cycle
  always_comb begin
    w_fv_nxt = r_frame_value;
    if (w_boundary) begin
      case (w_owner_nxt)
        OWN_A:   w_fv_nxt = data_a;
        OWN_B:   w_fv_nxt = data_b;
        default: w_fv_nxt = 16'h0000;
      endcase
    end
    w_anode_nxt = 4'b1111;
    if ((w_owner_nxt != OWN_NONE) && !(w_cnt_nxt < c_BLANK))
      w_anode_nxt = ~(4'b0001 << w_slot_nxt);
    case (w_slot_nxt)
      2'd0:    w_digit_nxt = w_fv_nxt[3:0];
      2'd1:    w_digit_nxt = w_fv_nxt[7:4];
      2'd2:    w_digit_nxt = w_fv_nxt[11:8];
      default: w_digit_nxt = w_fv_nxt[15:12];
    endcase
  end

  // State and registered outputs, cleared immediately on reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_owner       <= OWN_NONE;
      r_dwell       <= '0;
      r_cnt         <= '0;
      r_slot        <= 2'd0;
      r_frame_value <= 16'h0000;
      r_grant_a     <= 1'b0;
      r_grant_b     <= 1'b0;
      r_frame_done  <= 1'b0;
      r_anode       <= 4'b1111;
      r_digit       <= 4'h0;
    end else begin
      r_owner       <= w_owner_nxt;
      r_dwell       <= w_dwell_nxt;
      r_cnt         <= w_cnt_nxt;
      r_slot        <= w_slot_nxt;
      r_frame_value <= w_fv_nxt;
      r_grant_a     <= (w_owner_nxt == OWN_A);
      r_grant_b     <= (w_owner_nxt == OWN_B);
      r_frame_done  <= w_boundary;
      r_anode       <= w_anode_nxt;
      r_digit       <= w_digit_nxt;
    end
  end

  assign grant_a    = r_grant_a;
  assign grant_b    = r_grant_b;
  assign anode      = r_anode;
  assign digit      = r_digit;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan_scheduler
// Purpose  : Directed self-checking bench for display_scan_scheduler with
//            REFRESH_DIVIDE=8, BLANK_CYCLES=2, DWELL_FRAMES=2 (32-cycle frame).
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan_scheduler;

  logic        clock;
  logic        reset_n;
  logic        req_a, req_b;
  logic [15:0] data_a, data_b;
  logic        grant_a, grant_b, frame_done;
  logic [3:0]  anode, digit;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  display_scan_scheduler #(
    .REFRESH_DIVIDE(8),
    .BLANK_CYCLES  (2),
    .DWELL_FRAMES  (2)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_a     (req_a),
    .data_a    (data_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .grant_a   (grant_a),
    .grant_b   (grant_b),
    .anode     (anode),
    .digit     (digit),
    .frame_done(frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected anode for a cycle position within a frame
  function automatic logic [3:0] exp_anode(input int fc, input bit owned);
    logic [3:0] one_hot;
    int cnt;
    int slot;
    cnt  = fc % 8;
    slot = (fc / 8) % 4;
    one_hot = 4'b0001 << slot;
    if (!owned || cnt < 2) return 4'b1111;
    return ~one_hot;
  endfunction

  function automatic logic [3:0] exp_digit(input logic [15:0] val, input int fc);
    int slot;
    slot = (fc / 8) % 4;
    return val[4*slot +: 4];
  endfunction

  // Advance one clock and sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  // Reset, then release between edges; the DUT is then in cycle 0
  task automatic do_reset(input logic ra, input logic [15:0] da,
                          input logic rb, input logic [15:0] db);
    reset_n = 1'b0;
    req_a = ra; data_a = da; req_b = rb; data_b = db;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset(1'b0, 16'h0, 1'b0, 16'h0);
    n_checks++; if (anode !== 4'b1111) $display("FAIL reset_anode got=%b exp=1111", anode); else n_pass++;
    n_checks++; if (digit !== 4'h0) $display("FAIL reset_digit got=%h exp=0", digit); else n_pass++;
    n_checks++; if (grant_a !== 1'b0) $display("FAIL reset_grant_a got=%b exp=0", grant_a); else n_pass++;
    n_checks++; if (grant_b !== 1'b0) $display("FAIL reset_grant_b got=%b exp=0", grant_b); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got=%b exp=0", frame_done); else n_pass++;
  endtask

  task automatic test_idle();
    do_reset(1'b0, 16'h0, 1'b0, 16'h0);
    while (cyc < 100) begin
      step();
      n_checks++;
      if (anode !== 4'b1111 || grant_a !== 1'b0 || grant_b !== 1'b0)
        $display("FAIL idle_outputs cyc=%0d anode=%b ga=%b gb=%b exp anode=1111 grants=0",
                 cyc, anode, grant_a, grant_b);
      else n_pass++;
      n_checks++;
      if (frame_done !== ((cyc % 32) == 0))
        $display("FAIL idle_frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, ((cyc % 32) == 0));
      else n_pass++;
    end
  endtask

  task automatic test_single();
    do_reset(1'b1, 16'h1234, 1'b0, 16'h0);
    run_to(31);
    n_checks++; if (grant_a !== 1'b0) $display("FAIL single_grant_early got=%b exp=0", grant_a); else n_pass++;
    step();
    n_checks++; if (grant_a !== 1'b1) $display("FAIL single_grant_at32 got=%b exp=1", grant_a); else n_pass++;
    n_checks++; if (frame_done !== 1'b1) $display("FAIL single_frame_done got=%b exp=1", frame_done); else n_pass++;
    for (int fc = 0; fc < 32; fc++) begin
      if (fc > 0) step();
      n_checks++;
      if (anode !== exp_anode(fc, 1'b1) || digit !== exp_digit(16'h1234, fc))
        $display("FAIL single_scan fc=%0d anode=%b digit=%h exp anode=%b digit=%h",
                 fc, anode, digit, exp_anode(fc, 1'b1), exp_digit(16'h1234, fc));
      else n_pass++;
    end
  endtask

  // Continues from test_single: A owns frame 2 (cycles 32..63)
  task automatic test_dwell_switch();
    run_to(40);
    req_b  = 1'b1;
    data_b = 16'hABCD;
    run_to(64);
    n_checks++; if (grant_a !== 1'b1 || grant_b !== 1'b0)
      $display("FAIL dwell_keep_f3 ga=%b gb=%b exp ga=1 gb=0", grant_a, grant_b); else n_pass++;
    run_to(95);
    n_checks++; if (grant_a !== 1'b1 || grant_b !== 1'b0)
      $display("FAIL dwell_keep_f3_end ga=%b gb=%b exp ga=1 gb=0", grant_a, grant_b); else n_pass++;
    step();
    n_checks++; if (grant_a !== 1'b0 || grant_b !== 1'b1)
      $display("FAIL switch_to_b ga=%b gb=%b exp ga=0 gb=1", grant_a, grant_b); else n_pass++;
    for (int s = 0; s < 4; s++) begin
      run_to(96 + 8*s + 2);
      n_checks++;
      if (anode !== exp_anode(8*s + 2, 1'b1) || digit !== exp_digit(16'hABCD, 8*s + 2))
        $display("FAIL switch_scan slot=%0d anode=%b digit=%h exp anode=%b digit=%h",
                 s, anode, digit, exp_anode(8*s + 2, 1'b1), exp_digit(16'hABCD, 8*s + 2));
      else n_pass++;
    end
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic test_priority();
    do_reset(1'b0, 16'h1111, 1'b0, 16'h2222);
    run_to(5);
    req_a = 1'b1;
    req_b = 1'b1;
    run_to(31);
    n_checks++; if (grant_a !== 1'b0 || grant_b !== 1'b0)
      $display("FAIL prio_before ga=%b gb=%b exp ga=0 gb=0", grant_a, grant_b); else n_pass++;
    step();
    n_checks++; if (grant_a !== 1'b0 || grant_b !== 1'b1)
      $display("FAIL prio_grant ga=%b gb=%b exp ga=0 gb=1", grant_a, grant_b); else n_pass++;
    run_to(34);
    n_checks++; if (anode !== 4'b1110 || digit !== 4'h2)
      $display("FAIL prio_scan anode=%b digit=%h exp anode=1110 digit=2", anode, digit); else n_pass++;
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic test_coherence_release();
    do_reset(1'b1, 16'h1234, 1'b0, 16'h0);
    run_to(40);
    data_a = 16'hFFFF;
    run_to(42);
    n_checks++; if (digit !== 4'h3 || anode !== 4'b1101)
      $display("FAIL coh_hold_s1 anode=%b digit=%h exp anode=1101 digit=3", anode, digit); else n_pass++;
    run_to(58);
    n_checks++; if (digit !== 4'h1 || anode !== 4'b0111)
      $display("FAIL coh_hold_s3 anode=%b digit=%h exp anode=0111 digit=1", anode, digit); else n_pass++;
    run_to(66);
    n_checks++; if (digit !== 4'hF || anode !== 4'b1110)
      $display("FAIL coh_new_frame anode=%b digit=%h exp anode=1110 digit=f", anode, digit); else n_pass++;
    run_to(70);
    req_a = 1'b0;
    run_to(95);
    n_checks++; if (grant_a !== 1'b1 || anode !== 4'b0111)
      $display("FAIL release_hold ga=%b anode=%b exp ga=1 anode=0111", grant_a, anode); else n_pass++;
    step();
    n_checks++; if (grant_a !== 1'b0 || grant_b !== 1'b0)
      $display("FAIL release_grant ga=%b gb=%b exp ga=0 gb=0", grant_a, grant_b); else n_pass++;
    run_to(98);
    n_checks++; if (anode !== 4'b1111)
      $display("FAIL release_anode got=%b exp=1111", anode); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset(1'b1, 16'h1234, 1'b0, 16'h0);
    run_to(35);
    n_checks++; if (anode !== 4'b1110 || grant_a !== 1'b1)
      $display("FAIL areset_pre anode=%b ga=%b exp anode=1110 ga=1", anode, grant_a); else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (anode !== 4'b1111 || grant_a !== 1'b0 || grant_b !== 1'b0 || digit !== 4'h0)
      $display("FAIL areset_immediate anode=%b ga=%b gb=%b digit=%h exp 1111/0/0/0",
               anode, grant_a, grant_b, digit); else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    cyc = 0;
    run_to(31);
    n_checks++; if (grant_a !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL areset_restart_early ga=%b fd=%b exp ga=0 fd=0", grant_a, frame_done); else n_pass++;
    step();
    n_checks++; if (grant_a !== 1'b1 || frame_done !== 1'b1)
      $display("FAIL areset_restart_grant ga=%b fd=%b exp ga=1 fd=1", grant_a, frame_done); else n_pass++;
    run_to(34);
    n_checks++; if (anode !== 4'b1110 || digit !== 4'h4)
      $display("FAIL areset_restart_scan anode=%b digit=%h exp anode=1110 digit=4", anode, digit); else n_pass++;
    req_a = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    data_a = 16'h0; data_b = 16'h0;
    test_reset();
    test_idle();
    test_single();
    test_dwell_switch();
    test_priority();
    test_coherence_release();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
